operaciones_mac_pipe: RTL and testbench



---
 rtl/operaciones_mac_pipe_pkg.sv | 7 +
 rtl/operaciones_mac_pipe_if.sv | 15 +
 rtl/operaciones_mac_pipe_mac_sat_trunc.sv | 26 ++
 rtl/operaciones_mac_pipe.sv | 61 ++++++
 tb/tb_operaciones_mac_pipe.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/operaciones_mac_pipe_pkg.sv
// operaciones_mac_pipe_pkg: shared width/resolution defaults and mode encodings for the MAC pipeline.
package operaciones_mac_pipe_pkg;
   localparam int MAC_WIDTH = 16;
   localparam int MAC_FRAC = 8;
   localparam logic MAC_MODE_DIRECT = 1'b0;
   localparam logic MAC_MODE_ACC = 1'b1;
endpackage

// File: rtl/operaciones_mac_pipe_if.sv
// operaciones_mac_pipe_if: operand and result streams with valid/ready handshakes.
interface operaciones_mac_pipe_if
   import operaciones_mac_pipe_pkg::*;
#(parameter int WIDTH = MAC_WIDTH);
   logic in_valid, in_ready, mode, acc_clr, out_valid, out_ready, ovf, unf;
   logic [WIDTH-1:0] op_a, op_b, op_c, result;
   modport master (
      output in_valid, op_a, op_b, op_c, mode, acc_clr, out_ready,
      input  in_ready, out_valid, result, ovf, unf
   );
   modport slave (
      input  in_valid, op_a, op_b, op_c, mode, acc_clr, out_ready,
      output in_ready, out_valid, result, ovf, unf
   );
endinterface

// File: rtl/operaciones_mac_pipe_mac_sat_trunc.sv
// mac_sat_trunc: rounds/truncates a wide signed fixed-point sum to WIDTH bits with clamp flags.
module mac_sat_trunc
   import operaciones_mac_pipe_pkg::*;
#(
   parameter int WIDTH = MAC_WIDTH,
   parameter int FRAC = MAC_FRAC,
   parameter bit ROUND = 1'b0
) (
   input  logic signed [2*WIDTH+1:0] sum_i,
   output logic [WIDTH-1:0]          res_o,
   output logic                      ovf_o,
   output logic                      unf_o
);
   localparam int SW = 2*WIDTH+2;
   localparam logic [SW-1:0] HALF = ROUND ? {{(SW-1){1'b0}}, 1'b1} << (FRAC-1) : '0;
   localparam logic signed [SW-1:0] MAXV = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [SW-1:0] MINV = ~MAXV;
   logic signed [SW-1:0] r, q;
   always_comb begin
      r = sum_i + HALF;
      q = r >>> FRAC;
      ovf_o = q > MAXV;
      unf_o = q < MINV;
      res_o = ovf_o ? {1'b0, {(WIDTH-1){1'b1}}} : unf_o ? {1'b1, {(WIDTH-1){1'b0}}} : q[WIDTH-1:0];
   end
endmodule

// File: rtl/operaciones_mac_pipe.sv
// operaciones_mac_pipe: two-stage saturating multiply-add / multiply-accumulate with global stall.
module operaciones_mac_pipe
   import operaciones_mac_pipe_pkg::*;
#(
   parameter int WIDTH = MAC_WIDTH,
   parameter int FRAC = MAC_FRAC,
   parameter bit ROUND = 1'b0
) (
   input logic clk,
   input logic reset,
   operaciones_mac_pipe_if.slave bus
);
   localparam int PW = 2*WIDTH;
   localparam int SW = 2*WIDTH+2;
   logic en, v1_q, mode_q, clr_q, vo_q, ovf_q, unf_q, sat_ovf, sat_unf;
   logic signed [PW-1:0] prod_q, prod_d;
   logic signed [SW-1:0] c_al_q, c_al_d, addend, sum;
   logic [WIDTH-1:0] acc_q, res_q, sat_res;
   // acc is read straight from its register, so a back-to-back accumulate sees the prior update
   always_comb begin
      en = !vo_q || bus.out_ready;
      prod_d = {{WIDTH{bus.op_a[WIDTH-1]}}, bus.op_a} * {{WIDTH{bus.op_b[WIDTH-1]}}, bus.op_b};
      c_al_d = {{(WIDTH+2){bus.op_c[WIDTH-1]}}, bus.op_c} << FRAC;
      addend = mode_q == MAC_MODE_ACC ? (clr_q ? '0 : {{(WIDTH+2){acc_q[WIDTH-1]}}, acc_q} << FRAC) : c_al_q;
      sum = {{2{prod_q[PW-1]}}, prod_q} + addend;
   end
   mac_sat_trunc #(.WIDTH(WIDTH), .FRAC(FRAC), .ROUND(ROUND)) u_sat (
      .sum_i(sum),
      .res_o(sat_res),
      .ovf_o(sat_ovf),
      .unf_o(sat_unf)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         v1_q <= 1'b0;
         vo_q <= 1'b0;
         res_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
         acc_q <= '0;
      end else if (en) begin
         v1_q <= bus.in_valid;
         prod_q <= prod_d;
         c_al_q <= c_al_d;
         mode_q <= bus.mode;
         clr_q <= bus.acc_clr;
         vo_q <= v1_q;
         if (v1_q) begin
            res_q <= sat_res;
            ovf_q <= sat_ovf;
            unf_q <= sat_unf;
         end
         if (v1_q && mode_q == MAC_MODE_ACC) acc_q <= sat_res;
      end
   end
   assign bus.in_ready = en;
   assign bus.out_valid = vo_q;
   assign bus.result = res_q;
   assign bus.ovf = ovf_q;
   assign bus.unf = unf_q;
endmodule

// File: tb/tb_operaciones_mac_pipe.sv
// tb_operaciones_mac_pipe: directed and randomized checks of the MAC pipeline (truncating and rounding builds).
module tb_operaciones_mac_pipe;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int vectors = 0;
   int miscompares = 0;
   logic [15:0] acc_m = '0;

   always #5 clk = ~clk;

   operaciones_mac_pipe_if #(.WIDTH(16)) m();
   operaciones_mac_pipe_if #(.WIDTH(16)) mr();

   assign mr.in_valid = m.in_valid;
   assign mr.op_a = m.op_a;
   assign mr.op_b = m.op_b;
   assign mr.op_c = m.op_c;
   assign mr.mode = m.mode;
   assign mr.acc_clr = m.acc_clr;
   assign mr.out_ready = m.out_ready;

   operaciones_mac_pipe #(.WIDTH(16), .FRAC(8), .ROUND(1'b0)) dut (.clk(clk), .reset(reset), .bus(m.slave));
   operaciones_mac_pipe #(.WIDTH(16), .FRAC(8), .ROUND(1'b1)) dut_r (.clk(clk), .reset(reset), .bus(mr.slave));

   task automatic drive_one(input logic [15:0] a, b, c, input logic md, cl,
                            output logic [15:0] r, rr, output logic o, u, output int lat);
      m.op_a = a; m.op_b = b; m.op_c = c; m.mode = md; m.acc_clr = cl; m.in_valid = 1'b1;
      @(posedge clk); #1;
      m.in_valid = 1'b0;
      lat = 1;
      while (!m.out_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      r = m.result; rr = mr.result; o = m.ovf; u = m.unf;
   endtask

   task automatic model(input logic [15:0] a, b, c, input logic md, cl, output logic [17:0] e);
      longint p, s, q;
      p = longint'($signed(a)) * longint'($signed(b));
      s = p + (md ? (cl ? 64'sd0 : longint'($signed(acc_m)) * 256) : longint'($signed(c)) * 256);
      q = s >>> 8;
      if (q > 32767) e = {2'b10, 16'h7FFF};
      else if (q < -32768) e = {2'b01, 16'h8000};
      else e = {2'b00, q[15:0]};
      if (md) acc_m = e[15:0];
   endtask

   task automatic test_reset;
      m.in_valid = 1'b0; m.out_ready = 1'b0; m.mode = 1'b0; m.acc_clr = 1'b0;
      m.op_a = '0; m.op_b = '0; m.op_c = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({m.out_valid, m.ovf, m.unf, m.result} !== 19'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: got ov=%b ovf=%b unf=%b res=%h want all 0", m.out_valid, m.ovf, m.unf, m.result);
      end
      vectors++;
      if (m.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_in_ready: got %b want 1", m.in_ready);
      end
      reset = 1'b0;
      m.out_ready = 1'b1;
   endtask

   task automatic test_basic;
      logic [15:0] r, rr; logic o, u; int lat;
      drive_one(16'h0180, 16'h0200, 16'h0040, 1'b0, 1'b0, r, rr, o, u, lat);
      vectors++;
      if (r !== 16'h0340) begin miscompares++; $display("FAIL basic_result: got %h want 0340", r); end
      vectors++;
      if ({o, u} !== 2'b00) begin miscompares++; $display("FAIL basic_flags: got %b want 00", {o, u}); end
      vectors++;
      if (lat != 2) begin miscompares++; $display("FAIL basic_latency: got %0d want 2", lat); end
   endtask

   task automatic test_saturate;
      logic [15:0] r, rr; logic o, u; int lat;
      drive_one(16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, 1'b0, r, rr, o, u, lat);
      vectors++;
      if ({o, u, r} !== {2'b10, 16'h7FFF}) begin
         miscompares++; $display("FAIL sat_pos: got ovf=%b unf=%b res=%h want 1 0 7fff", o, u, r);
      end
      drive_one(16'h8000, 16'h7FFF, 16'h0000, 1'b0, 1'b0, r, rr, o, u, lat);
      vectors++;
      if ({o, u, r} !== {2'b01, 16'h8000}) begin
         miscompares++; $display("FAIL sat_neg: got ovf=%b unf=%b res=%h want 0 1 8000", o, u, r);
      end
   endtask

   task automatic test_round;
      logic [15:0] r, rr; logic o, u; int lat;
      drive_one(16'hFFFF, 16'h0080, 16'h0000, 1'b0, 1'b0, r, rr, o, u, lat);
      vectors++;
      if (r !== 16'hFFFF) begin miscompares++; $display("FAIL trunc_neg_half: got %h want ffff", r); end
      vectors++;
      if (rr !== 16'h0000) begin miscompares++; $display("FAIL round_neg_half: got %h want 0000", rr); end
      drive_one(16'h0001, 16'h0080, 16'h0000, 1'b0, 1'b0, r, rr, o, u, lat);
      vectors++;
      if (r !== 16'h0000) begin miscompares++; $display("FAIL trunc_pos_half: got %h want 0000", r); end
      vectors++;
      if (rr !== 16'h0001) begin miscompares++; $display("FAIL round_pos_half: got %h want 0001", rr); end
   endtask

   task automatic test_back_to_back;
      logic [15:0] got[$];
      logic [15:0] want [5] = '{16'h0100, 16'h0200, 16'h0300, 16'h0600, 16'h0400};
      logic md [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      logic cl [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 8; i++) begin
         m.in_valid = i < 5;
         m.op_a = 16'h0100; m.op_b = 16'h0100; m.op_c = 16'h0500;
         m.mode = i < 5 ? md[i] : 1'b0;
         m.acc_clr = i < 5 ? cl[i] : 1'b0;
         @(posedge clk); #1;
         if (m.out_valid) got.push_back(m.result);
      end
      m.in_valid = 1'b0;
      vectors++;
      if (got.size() != 5) begin miscompares++; $display("FAIL b2b_count: got %0d want 5", got.size()); end
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (i >= got.size() || got[i] !== want[i]) begin
            miscompares++;
            $display("FAIL b2b_item%0d: got %h want %h", i, i < got.size() ? got[i] : 16'hxxxx, want[i]);
         end
      end
   endtask

   task automatic test_random;
      logic [17:0] exp_q[$];
      logic [17:0] held, e, obs;
      logic stall = 1'b0;
      int acc_n = 0, out_n = 0, cyc = 0;
      reset = 1'b1; m.in_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      acc_m = '0;
      while (out_n < 1000 && cyc < 20000) begin
         m.in_valid = acc_n < 1000 && $urandom_range(0, 1) == 1;
         m.out_ready = $urandom_range(0, 1) == 1;
         m.op_a = 16'($urandom); m.op_b = 16'($urandom); m.op_c = 16'($urandom);
         m.mode = $urandom_range(0, 1) == 1; m.acc_clr = $urandom_range(0, 3) == 0;
         #1;
         obs = {m.ovf, m.unf, m.result};
         if (stall) begin
            vectors++;
            if (!m.out_valid || obs !== held) begin
               miscompares++; $display("FAIL stall_hold: got ov=%b %h want 1 %h", m.out_valid, obs, held);
            end
         end
         stall = m.out_valid && !m.out_ready;
         held = obs;
         if (stall) begin
            vectors++;
            if (m.in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready: got %b want 0", m.in_ready); end
         end
         if (m.out_valid && m.out_ready) begin
            vectors++;
            if (exp_q.size() == 0 || obs !== exp_q[0]) begin
               miscompares++;
               $display("FAIL random_item%0d: got %h want %h", out_n, obs, exp_q.size() ? exp_q[0] : 18'hxxxxx);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            out_n++;
         end
         if (m.in_valid && m.in_ready) begin
            model(m.op_a, m.op_b, m.op_c, m.mode, m.acc_clr, e);
            exp_q.push_back(e);
            acc_n++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      m.in_valid = 1'b0; m.out_ready = 1'b1;
      vectors++;
      if (out_n != 1000 || exp_q.size() != 0) begin
         miscompares++; $display("FAIL random_count: got %0d out, %0d pending want 1000, 0", out_n, exp_q.size());
      end
   endtask

   task automatic test_reset_flight;
      logic [15:0] r, rr; logic o, u; int lat;
      m.out_ready = 1'b1;
      m.op_a = 16'h0100; m.op_b = 16'h0100; m.op_c = 16'h0000; m.mode = 1'b1;
      m.acc_clr = 1'b1; m.in_valid = 1'b1;
      @(posedge clk); #1;
      m.acc_clr = 1'b0;
      @(posedge clk); #1;
      m.in_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (m.out_valid !== 1'b0 || m.in_ready !== 1'b1) begin
         miscompares++; $display("FAIL flight_reset: got ov=%b ir=%b want 0 1", m.out_valid, m.in_ready);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if (m.out_valid !== 1'b0) begin miscompares++; $display("FAIL flight_stale: got ov=%b want 0", m.out_valid); end
      drive_one(16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, r, rr, o, u, lat);
      vectors++;
      if (r !== 16'h0100 || lat != 2) begin
         miscompares++; $display("FAIL flight_acc_zero: got %h lat %0d want 0100 lat 2", r, lat);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturate();
      test_round();
      test_back_to_back();
      test_random();
      test_reset_flight();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
